hack_cpu_ctrl: RTL and testbench

Multi-cycle Hack CPU control and datapath stage that sits directly upstream of the Hack ALU.
- Fetches instructions from ROM and decodes A and C instructions.
- Holds the A, D and PC registers.
- Drives ALU operands and control bits, and consumes the ALU result and flags.
- Performs data-memory reads/writes through req/ack handshakes and evaluates jumps.

---
 rtl/hack_cpu_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_hack_cpu_ctrl.sv | 537 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_cpu_ctrl.sv
`timescale 1ns/1ps
// hack_cpu_ctrl
// ----------------------------------------------------------------------------
// Multi-cycle Hack CPU controller and register datapath. The block sits in
// front of an external combinational Hack ALU. It fetches instructions over a
// ROM req/ack handshake, decodes A- and C-instructions, holds the A, D and PC
// registers, and performs data-memory reads and writes over a second req/ack
// handshake.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   rom_req/addr/ack/data   instruction fetch handshake (rom_addr = pc)
//   mem_rd_req, mem_wr_req  data access requests
//   mem_addr, mem_wdata     data address / write data
//   mem_ack, mem_rdata      data access completion / read data
//   alu_x, alu_y            ALU operands (D, and A or MDR selected by ir[12])
//   alu_zx..alu_no          ALU control bits (ir[11:6])
//   alu_out, alu_zr, alu_ng ALU result and flags
//   pc                      current program counter
//
// Optional build macro HACK_CPU_RETIRE_EN adds:
//   retire_valid  one-cycle pulse per completed instruction
//   retire_pc     address of the instruction that just completed
// ----------------------------------------------------------------------------
module hack_cpu_ctrl #(
    parameter int PC_W   = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              rom_req,
    output logic [PC_W-1:0]   rom_addr,
    input  logic              rom_ack,
    input  logic [DATA_W-1:0] rom_data,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [PC_W-1:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic              alu_zx,
    output logic              alu_nx,
    output logic              alu_zy,
    output logic              alu_ny,
    output logic              alu_f,
    output logic              alu_no,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zr,
    input  logic              alu_ng,
`ifdef HACK_CPU_RETIRE_EN
    output logic              retire_valid,
    output logic [PC_W-1:0]   retire_pc,
`endif
    output logic [PC_W-1:0]   pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMRD,
        S_EXEC,
        S_MEMWR
    } state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [PC_W-1:0]     waddr_q, waddr_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   d_q, d_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

`ifdef HACK_CPU_RETIRE_EN
    logic                retire_valid_q, retire_valid_d;
    logic [PC_W-1:0]     retire_pc_q, retire_pc_d;
    // pc is already advanced by the time an M write completes, so the
    // instruction address is kept aside for the MEMWR retire.
    logic [PC_W-1:0]     inst_pc_q, inst_pc_d;
`endif

    // Instruction fields; bits 14:13 of a C-instruction carry no meaning.
    logic              is_c;
    logic              sel_m;
    logic              dest_a, dest_d, dest_m;
    logic              j_lt, j_eq, j_gt;
    logic              jump;
    logic [PC_W-1:0]   pc_inc;

    assign is_c   = ir_q[15];
    assign sel_m  = ir_q[12];
    assign dest_a = ir_q[5];
    assign dest_d = ir_q[4];
    assign dest_m = ir_q[3];
    assign j_lt   = ir_q[2];
    assign j_eq   = ir_q[1];
    assign j_gt   = ir_q[0];

    assign jump   = (j_lt & alu_ng) | (j_eq & alu_zr) | (j_gt & ~alu_ng & ~alu_zr);
    // Natural PC_W-bit overflow gives the 0x7FFF -> 0x0000 wrap.
    assign pc_inc = pc_q + PC_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        waddr_d = waddr_q;
        a_d     = a_q;
        d_d     = d_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        wdata_d = wdata_q;
`ifdef HACK_CPU_RETIRE_EN
        retire_valid_d = 1'b0;
        retire_pc_d    = retire_pc_q;
        inst_pc_d      = inst_pc_q;
`endif
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (rom_ack) begin
                    ir_d    = rom_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!is_c) begin
                    a_d     = {1'b0, ir_q[DATA_W-2:0]};
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
`ifdef HACK_CPU_RETIRE_EN
                    retire_valid_d = 1'b1;
                    retire_pc_d    = pc_q;
`endif
                end else if (sel_m) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_MEMRD: begin
                if (mem_ack) begin
                    mdr_d   = mem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Write address and jump target both come from A before
                // this instruction's own A write lands.
                waddr_d = a_q[PC_W-1:0];
                wdata_d = alu_out;
                if (dest_a) a_d = alu_out;
                if (dest_d) d_d = alu_out;
                pc_d    = jump ? a_q[PC_W-1:0] : pc_inc;
                state_d = dest_m ? S_MEMWR : S_FETCH;
`ifdef HACK_CPU_RETIRE_EN
                inst_pc_d = pc_q;
                if (!dest_m) begin
                    retire_valid_d = 1'b1;
                    retire_pc_d    = pc_q;
                end
`endif
            end
            S_MEMWR: begin
                if (mem_ack) begin
                    state_d = S_FETCH;
`ifdef HACK_CPU_RETIRE_EN
                    retire_valid_d = 1'b1;
                    retire_pc_d    = inst_pc_q;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            waddr_q <= '0;
            a_q     <= '0;
            d_q     <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
            wdata_q <= '0;
`ifdef HACK_CPU_RETIRE_EN
            retire_valid_q <= 1'b0;
            retire_pc_q    <= '0;
            inst_pc_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            waddr_q <= waddr_d;
            a_q     <= a_d;
            d_q     <= d_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            wdata_q <= wdata_d;
`ifdef HACK_CPU_RETIRE_EN
            retire_valid_q <= retire_valid_d;
            retire_pc_q    <= retire_pc_d;
            inst_pc_q      <= inst_pc_d;
`endif
        end
    end

    // Requests come straight from the state register, so they stay high with
    // stable address/data until the ack moves the state on.
    assign rom_req    = (state_q == S_FETCH);
    assign rom_addr   = pc_q;
    assign mem_rd_req = (state_q == S_MEMRD);
    assign mem_wr_req = (state_q == S_MEMWR);
    assign mem_addr   = (state_q == S_MEMWR) ? waddr_q : a_q[PC_W-1:0];
    assign mem_wdata  = wdata_q;

    assign alu_x  = d_q;
    assign alu_y  = sel_m ? mdr_q : a_q;
    assign alu_zx = ir_q[11];
    assign alu_nx = ir_q[10];
    assign alu_zy = ir_q[9];
    assign alu_ny = ir_q[8];
    assign alu_f  = ir_q[7];
    assign alu_no = ir_q[6];
    assign pc     = pc_q;

`ifdef HACK_CPU_RETIRE_EN
    assign retire_valid = retire_valid_q;
    assign retire_pc    = retire_pc_q;
`endif

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
`timescale 1ns/1ps
module tb_hack_cpu_ctrl;

    localparam int PC_W   = 15;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rom_req;
    logic [PC_W-1:0]   rom_addr;
    logic              rom_ack;
    logic [15:0]       rom_data;
    logic              mem_rd_req, mem_wr_req;
    logic [PC_W-1:0]   mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ack;
    logic [15:0]       mem_rdata;
    logic [15:0]       alu_x, alu_y, alu_out;
    logic              alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic              alu_zr, alu_ng;
    logic [PC_W-1:0]   pc;
`ifdef HACK_CPU_RETIRE_EN
    logic              retire_valid;
    logic [PC_W-1:0]   retire_pc;
`endif

    always #5 clk = ~clk;

    hack_cpu_ctrl #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
        .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
`ifdef HACK_CPU_RETIRE_EN
        .retire_valid(retire_valid), .retire_pc(retire_pc),
`endif
        .pc(pc)
    );

    // Hack ALU model
    logic [15:0] ax1, ax2, ay1, ay2, ao1;
    always_comb begin
        ax1 = alu_zx ? 16'h0 : alu_x;
        ax2 = alu_nx ? ~ax1 : ax1;
        ay1 = alu_zy ? 16'h0 : alu_y;
        ay2 = alu_ny ? ~ay1 : ay1;
        ao1 = alu_f ? (ax2 + ay2) : (ax2 & ay2);
        alu_out = alu_no ? ~ao1 : ao1;
        alu_zr = (alu_out == 16'h0);
        alu_ng = alu_out[15];
    end

    logic [15:0] rom [0:32767];
    logic [15:0] ram [0:32767];

    int checks = 0;
    int errors = 0;
    bit hold_mem = 1'b0;
    int mem_req_cycles = 0;

    typedef struct packed {
        logic [14:0] addr;
        logic [15:0] data;
    } wr_t;
    wr_t         exp_wr_q[$];
    wr_t         obs_wr_q[$];
    logic [14:0] exp_rd_q[$];
    logic [14:0] obs_rd_q[$];
    logic [14:0] ret_q[$];

    // ROM responder: 0-2 wait cycles, one-cycle ack
    initial begin : rom_resp
        bit rom_busy;
        int rom_wait;
        rom_busy = 1'b0;
        rom_wait = 0;
        rom_ack  = 1'b0;
        rom_data = 16'h0;
        forever begin
            @(negedge clk);
            if (rom_ack) begin
                rom_ack  = 1'b0;
                rom_busy = 1'b0;
            end else if (rom_req) begin
                if (!rom_busy) begin
                    rom_busy = 1'b1;
                    rom_wait = int'($urandom_range(0, 2));
                end
                if (rom_wait == 0) begin
                    rom_ack  = 1'b1;
                    rom_data = rom[rom_addr];
                end else begin
                    rom_wait--;
                end
            end else begin
                rom_busy = 1'b0;
            end
        end
    end

    // RAM responder: records every completed access as observed output
    initial begin : ram_resp
        bit mem_busy;
        int mem_wait;
        mem_busy  = 1'b0;
        mem_wait  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack  = 1'b0;
                mem_busy = 1'b0;
            end else if ((mem_rd_req || mem_wr_req) && !hold_mem) begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    mem_wait = int'($urandom_range(0, 2));
                end
                if (mem_wait == 0) begin
                    mem_ack = 1'b1;
                    if (mem_wr_req) begin
                        ram[mem_addr] = mem_wdata;
                        obs_wr_q.push_back({mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = ram[mem_addr];
                        obs_rd_q.push_back(mem_addr);
                    end
                end else begin
                    mem_wait--;
                end
            end else begin
                mem_busy = 1'b0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mem_rd_req || mem_wr_req) mem_req_cycles++;
`ifdef HACK_CPU_RETIRE_EN
            if (retire_valid) ret_q.push_back(retire_pc);
`endif
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns the address of the next new fetch request (bounded wait).
    task automatic next_fetch(output logic [14:0] addr, output bit ok);
        int n;
        n = 0;
        while (rom_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (!rom_req && n < 400) begin
            @(negedge clk);
            n++;
        end
        ok   = rom_req;
        addr = rom_addr;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hold_mem = 1'b0;
        repeat (3) @(negedge clk);
        exp_wr_q.delete();
        obs_wr_q.delete();
        exp_rd_q.delete();
        obs_rd_q.delete();
        ret_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic load_main();
        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
        rom[0]  = 16'h0005;  // @5
        rom[1]  = 16'h8C10;  // D=A (bits 14:13 clear)
        rom[2]  = 16'h0064;  // @100
        rom[3]  = 16'hE7C8;  // M=D+1
        rom[4]  = 16'h0007;  // @7
        rom[5]  = 16'hFCA8;  // AM=M-1
        rom[6]  = 16'hEA90;  // D=0
        rom[7]  = 16'h0014;  // @20
        rom[8]  = 16'hE302;  // D;JEQ
        rom[20] = 16'hEFD0;  // D=1
        rom[21] = 16'h0014;  // @20
        rom[22] = 16'hE302;  // D;JEQ
        ram[7]  = 16'h0003;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rom_req, mem_rd_req, mem_wr_req} !== 3'b000) begin
            errors++;
            $display("FAIL reset_req: got %b want 000", {rom_req, mem_rd_req, mem_wr_req});
        end
        checks++;
        if (pc !== 15'h0 || mem_addr !== 15'h0) begin
            errors++;
            $display("FAIL reset_pc_a: pc=%h A=%h want 0", pc, mem_addr);
        end
        checks++;
        if (alu_x !== 16'h0 || alu_y !== 16'h0 || mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_d_ir: x=%h y=%h wdata=%h want 0", alu_x, alu_y, mem_wdata);
        end
        load_main();
        rst_n = 1'b1;
        checks++;
        if (rom_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: rom_req=%b want 0", rom_req);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 15'h0) begin
            errors++;
            $display("FAIL reset_first_fetch: rom_req=%b addr=%h want 1/0", rom_req, rom_addr);
        end
        $display("test_reset done");
    endtask

    task automatic test_a_instr();
        logic [14:0] fa;
        bit ok;
        int base;
        rst_n = 1'b0;
        @(negedge clk);
        load_main();
        do_reset();
        base = mem_req_cycles;
        next_fetch(fa, ok);
        checks++;
        if (!ok || fa !== 15'd0) begin
            errors++;
            $display("FAIL a_fetch0: got %h ok=%0d want 0", fa, ok);
        end
        next_fetch(fa, ok);
        checks++;
        if (!ok || fa !== 15'd1) begin
            errors++;
            $display("FAIL a_fetch1: got %h ok=%0d want 1", fa, ok);
        end
        checks++;
        if (mem_addr !== 15'd5 || pc !== 15'd1) begin
            errors++;
            $display("FAIL a_regs: A=%h pc=%h want 5/1", mem_addr, pc);
        end
        checks++;
        if (mem_req_cycles !== base) begin
            errors++;
            $display("FAIL a_no_mem: mem req cycles=%0d want %0d", mem_req_cycles - base, 0);
        end
        $display("test_a_instr done");
    endtask

    task automatic test_mem_write();
        logic [14:0] fa;
        bit ok;
        wr_t w, e;
        next_fetch(fa, ok);
        checks++;
        if (!ok || fa !== 15'd2 || alu_x !== 16'd5) begin
            errors++;
            $display("FAIL mw_d_eq_a: fetch=%h D=%h want 2/0005", fa, alu_x);
        end
        exp_wr_q.push_back('{addr: 15'd100, data: 16'd6});
        next_fetch(fa, ok);
        next_fetch(fa, ok);
        checks++;
        if (!ok || fa !== 15'd4 || pc !== 15'd4) begin
            errors++;
            $display("FAIL mw_fetch4: fetch=%h pc=%h want 4", fa, pc);
        end
        checks++;
        if (obs_wr_q.size() == 0) begin
            errors++;
            $display("FAIL mw_write: no write observed, want addr 100 data 6");
        end else begin
            w = obs_wr_q.pop_front();
            e = exp_wr_q.pop_front();
            if (w !== e) begin
                errors++;
                $display("FAIL mw_write: got addr=%0d data=%h want addr=%0d data=%h",
                         w.addr, w.data, e.addr, e.data);
            end
        end
        checks++;
        if (alu_x !== 16'd5 || mem_addr !== 15'd100) begin
            errors++;
            $display("FAIL mw_regs: D=%h A=%h want 5/100", alu_x, mem_addr);
        end
        $display("test_mem_write done");
    endtask

    task automatic test_rmw();
        logic [14:0] fa;
        bit ok;
        logic [14:0] r, er;
        wr_t w, e;
        exp_rd_q.push_back(15'd7);
        exp_wr_q.push_back('{addr: 15'd7, data: 16'd2});
        next_fetch(fa, ok);
        next_fetch(fa, ok);
        checks++;
        if (!ok || fa !== 15'd6) begin
            errors++;
            $display("FAIL rmw_fetch6: got %h want 6", fa);
        end
        checks++;
        if (obs_rd_q.size() == 0) begin
            errors++;
            $display("FAIL rmw_read: no read observed, want addr 7");
        end else begin
            r  = obs_rd_q.pop_front();
            er = exp_rd_q.pop_front();
            if (r !== er) begin
                errors++;
                $display("FAIL rmw_read: got addr=%0d want %0d", r, er);
            end
        end
        checks++;
        if (obs_wr_q.size() == 0) begin
            errors++;
            $display("FAIL rmw_write: no write observed, want addr 7 data 2");
        end else begin
            w = obs_wr_q.pop_front();
            e = exp_wr_q.pop_front();
            if (w !== e) begin
                errors++;
                $display("FAIL rmw_write: got addr=%0d data=%h want addr=%0d data=%h",
                         w.addr, w.data, e.addr, e.data);
            end
        end
        checks++;
        if (mem_addr !== 15'd2) begin
            errors++;
            $display("FAIL rmw_a: A=%h want 2", mem_addr);
        end
        $display("test_rmw done");
    endtask

    task automatic test_jump();
        logic [14:0] fa;
        bit ok;
        logic [14:0] exp_seq [6];
        exp_seq = '{15'd7, 15'd8, 15'd20, 15'd21, 15'd22, 15'd23};
        for (int i = 0; i < 6; i++) begin
            next_fetch(fa, ok);
            checks++;
            if (!ok || fa !== exp_seq[i]) begin
                errors++;
                $display("FAIL jump_seq[%0d]: got %h ok=%0d want %h", i, fa, ok, exp_seq[i]);
            end
            if (i == 2) begin
                checks++;
                if (pc !== 15'd20 || alu_x !== 16'd0) begin
                    errors++;
                    $display("FAIL jump_taken: pc=%h D=%h want 20/0", pc, alu_x);
                end
            end
        end
        checks++;
        if (pc !== 15'd23 || alu_x !== 16'd1) begin
            errors++;
            $display("FAIL jump_not_taken: pc=%h D=%h want 23/1", pc, alu_x);
        end
        $display("test_jump done");
    endtask

    task automatic test_reset_mid_write();
        logic [14:0] fa;
        bit ok;
        int n;
        rst_n = 1'b0;
        @(negedge clk);
        rom[0] = 16'h0032;  // @50
        rom[1] = 16'hEFC8;  // M=1
        rom[2] = 16'h0000;
        do_reset();
        hold_mem = 1'b1;
        next_fetch(fa, ok);
        next_fetch(fa, ok);
        n = 0;
        while (!mem_wr_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mem_wr_req !== 1'b1 || mem_addr !== 15'd50 || mem_wdata !== 16'd1) begin
            errors++;
            $display("FAIL rst_wr_req: req=%b addr=%0d data=%h want 1/50/0001",
                     mem_wr_req, mem_addr, mem_wdata);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (mem_wr_req !== 1'b1 || mem_addr !== 15'd50 || mem_wdata !== 16'd1) begin
            errors++;
            $display("FAIL rst_wr_hold: req=%b addr=%0d data=%h want 1/50/0001",
                     mem_wr_req, mem_addr, mem_wdata);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (mem_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_wr_drop: mem_wr_req=%b want 0", mem_wr_req);
        end
        @(negedge clk);
        hold_mem = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_wr_q.size() != 0) begin
            errors++;
            $display("FAIL rst_wr_abandon: writes=%0d want 0", obs_wr_q.size());
        end
        rst_n = 1'b1;
        checks++;
        if (rom_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: rom_req=%b want 0", rom_req);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 15'h0) begin
            errors++;
            $display("FAIL rst_refetch: rom_req=%b addr=%h want 1/0", rom_req, rom_addr);
        end
        $display("test_reset_mid_write done");
    endtask

    task automatic test_pc_wrap();
        logic [14:0] fa;
        bit ok;
        logic [14:0] exp_seq [4];
        exp_seq = '{15'h0000, 15'h0001, 15'h7FFF, 15'h0000};
        rst_n = 1'b0;
        @(negedge clk);
        rom[0]       = 16'h7FFF;  // @0x7FFF
        rom[1]       = 16'hEA87;  // 0;JMP
        rom[15'h7FFF] = 16'hEA80; // NOP
        do_reset();
        for (int i = 0; i < 4; i++) begin
            next_fetch(fa, ok);
            checks++;
            if (!ok || fa !== exp_seq[i]) begin
                errors++;
                $display("FAIL wrap_seq[%0d]: got %h ok=%0d want %h", i, fa, ok, exp_seq[i]);
            end
            if (i == 2) begin
                checks++;
                if (pc !== 15'h7FFF || mem_addr !== 15'h7FFF) begin
                    errors++;
                    $display("FAIL wrap_top: pc=%h A=%h want 7fff", pc, mem_addr);
                end
            end
        end
        checks++;
        if (pc !== 15'h0000) begin
            errors++;
            $display("FAIL wrap_pc: pc=%h want 0000", pc);
        end
        $display("test_pc_wrap done");
    endtask

`ifdef HACK_CPU_RETIRE_EN
    task automatic test_retire();
        logic [14:0] fa;
        bit ok;
        logic [14:0] exp_ret [12];
        logic [14:0] r;
        exp_ret = '{15'd0, 15'd1, 15'd2, 15'd3, 15'd4, 15'd5, 15'd6, 15'd7,
                    15'd8, 15'd20, 15'd21, 15'd22};
        rst_n = 1'b0;
        @(negedge clk);
        load_main();
        do_reset();
        for (int i = 0; i < 13; i++) next_fetch(fa, ok);
        @(negedge clk);
        checks++;
        if (ret_q.size() != 12) begin
            errors++;
            $display("FAIL retire_count: got %0d want 12", ret_q.size());
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (ret_q.size() == 0) begin
                errors++;
                $display("FAIL retire_pc[%0d]: missing want %h", i, exp_ret[i]);
            end else begin
                r = ret_q.pop_front();
                if (r !== exp_ret[i]) begin
                    errors++;
                    $display("FAIL retire_pc[%0d]: got %h want %h", i, r, exp_ret[i]);
                end
            end
        end
        $display("test_retire done");
    endtask
`endif

    initial begin : main
        for (int i = 0; i < 32768; i++) begin
            rom[i] = 16'h0000;
            ram[i] = 16'h0000;
        end
        test_reset();
        test_a_instr();
        test_mem_write();
        test_rmw();
        test_jump();
        test_reset_mid_write();
        test_pc_wrap();
`ifdef HACK_CPU_RETIRE_EN
        test_retire();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
